mand_avm_frame_writer: RTL and testbench
========================================

MAND_AVM_FRAME_WRITER -- requirements
Module: mand_avm_frame_writer

Interface
REQ-001 Parameter DATA_W, default 32, pixel/Avalon write data width.
REQ-002 Parameter ADDR_W, default 32, Avalon address width.
REQ-003 Parameter FIFO_DEPTH, default 16, pixel buffer entries; power of two, >=2.
REQ-004 Parameters MAX_H, MAX_V, defaults 640, 480, frame size in pixels.
REQ-005 Parameter BYTES_PER_PIX, default 4, address stride per pixel.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  frame start request; level, sampled in IDLE only.
REQ-009 frame_base  in  ADDR_W  frame buffer byte base address; latched on accepted start.
REQ-010 pix_valid  in  1  producer pixel strobe.
REQ-011 pix_data  in  DATA_W  producer pixel word.
REQ-012 pix_ready  out  1  buffer can accept pixel this cycle.
REQ-013 calc_done  in  1  producer finished; may pulse one cycle.
REQ-014 avm_m0_address  out  ADDR_W  Avalon write address.
REQ-015 avm_m0_write  out  1  Avalon write request.
REQ-016 avm_m0_writedata  out  DATA_W  Avalon write data.
REQ-017 avm_m0_waitrequest  in  1  Avalon slave stall.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 done  out  1  one-cycle pulse at frame completion.
REQ-020 overflow  out  1  sticky: pixel offered while pix_ready low in RUN.
REQ-021 pix_count  out  clog2(MAX_H*MAX_V+1)  pixels written this frame.

Function
REQ-022 States IDLE, RUN, DRAIN; encoding free.
REQ-023 IDLE & start: latch frame_base, clear pix_count, FIFO, overflow, calc_done flag, pixel index; -> RUN next cycle.
REQ-024 start while busy ignored.
REQ-025 pix_ready = (state==RUN) & (FIFO occupancy < FIFO_DEPTH); no credit for a same-cycle pop.
REQ-026 Push on pix_valid & pix_ready; pix_valid with pix_ready low in RUN drops pixel, sets overflow; pix_valid in IDLE/DRAIN ignored, no flag.
REQ-027 Write register loads FIFO head when FIFO non-empty and (avm_m0_write==0 or avm_m0_waitrequest==0); avm_m0_write set in same load.
REQ-028 Transfer completes on cycle avm_m0_write & !avm_m0_waitrequest; then avm_m0_write clears unless next entry loaded that edge (back-to-back, one word/cycle sustained).
REQ-029 While avm_m0_write & avm_m0_waitrequest: address, writedata, write held stable.
REQ-030 Latency: pixel pushed at edge N appears on avm_m0_write earliest after edge N+1.
REQ-031 avm_m0_address = frame_base + index*BYTES_PER_PIX, index = pixel sequence number, ADDR_W wrap-around modulo.
REQ-032 index increments per loaded entry; after MAX_H*MAX_V-1 wraps to 0.
REQ-033 pix_count increments per completed transfer, saturates at MAX_H*MAX_V.
REQ-034 calc_done in RUN latched; state -> DRAIN next cycle; pixel pushed same cycle as calc_done still accepted.
REQ-035 DRAIN: no pushes; exit when FIFO empty and no write pending -> IDLE with done=1 for exactly that one cycle.
REQ-036 RUN also -> DRAIN when pix_count reaches MAX_H*MAX_V.
REQ-037 Simultaneous push and pop: occupancy unchanged, both take effect.

Reset
REQ-038 rst asserted: state IDLE, FIFO empty, index 0; avm_m0_write, avm_m0_writedata, avm_m0_address, pix_count, busy, done, overflow, pix_ready all 0.
REQ-039 rst mid-frame aborts immediately; in-flight write dropped, no done pulse.

Verification
REQ-040 start, frame_base=0x1000, 3 pixels A,B,C consecutive, waitrequest=0 -> writes A@0x1000,B@0x1004,C@0x1008 back-to-back; calc_done -> done pulse, pix_count=3.
REQ-041 waitrequest high 5 cycles on first write -> address/data stable 5 cycles; FIFO holds later pixels; order preserved.
REQ-042 FIFO_DEPTH=4, waitrequest stuck high, 6 pixels offered -> pix_ready low after 4 (+1 in write register), overflow=1, dropped pixels never written.
REQ-043 MAX_H=2, MAX_V=2, 5 pixels -> -> DRAIN after 4th completed transfer; 5th ignored, not written; address returns to base only on next frame.
REQ-044 rst pulse during DRAIN with pending write -> all outputs 0 next edge, busy=0, no done.
REQ-045 start held during RUN -> no restart; after done, start re-latches new frame_base, clears overflow and pix_count.

Source files
------------

// File: rtl/mand_avm_frame_writer_if.sv
// Avalon-MM write-master bus used by the frame writer.
interface mand_avm_frame_writer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_write;
  logic [DATA_W-1:0] avm_m0_writedata;
  logic              avm_m0_waitrequest;

  modport master (
    output avm_m0_address,
    output avm_m0_write,
    output avm_m0_writedata,
    input  avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_address,
    input  avm_m0_write,
    input  avm_m0_writedata,
    output avm_m0_waitrequest
  );

endinterface

// File: rtl/mand_avm_frame_writer.sv
// Buffers producer pixels in a small FIFO and writes them linearly into a
// frame buffer over Avalon-MM, one word per cycle when the slave allows.
module mand_avm_frame_writer #(
  parameter  int unsigned DATA_W        = 32,
  parameter  int unsigned ADDR_W        = 32,
  parameter  int unsigned FIFO_DEPTH    = 16,
  parameter  int unsigned MAX_H         = 640,
  parameter  int unsigned MAX_V         = 480,
  parameter  int unsigned BYTES_PER_PIX = 4,
  localparam int unsigned TOTAL         = MAX_H * MAX_V,
  localparam int unsigned CNT_W         = $clog2(TOTAL + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       frame_base,
  input  logic                    pix_valid,
  input  logic [DATA_W-1:0]       pix_data,
  output logic                    pix_ready,
  input  logic                    calc_done,
  mand_avm_frame_writer_if.master avm,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [CNT_W-1:0]        pix_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              full_q, full_d;        // every pixel of the frame has been loaded
  logic              calc_flag_q, calc_flag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  pix_count_q, pix_count_d;
  logic              pix_ready_q, pix_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic push, pop, load, complete;

  // Next-state, FIFO bookkeeping and write-register control
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    idx_d       = idx_q;
    full_d      = full_q;
    calc_flag_d = calc_flag_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = write_q;
    pix_count_d = pix_count_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    complete    = write_q & ~avm.avm_m0_waitrequest;

    push = (state_q == RUN) & pix_valid & pix_ready_q;
    if ((state_q == RUN) && pix_valid && !pix_ready_q) begin
      overflow_d = 1'b1;
    end

    // Entries beyond the last pixel of the frame are discarded, not written
    if (occ_q != '0) begin
      if (full_q) begin
        pop = 1'b1;
      end else if (!write_q || !avm.avm_m0_waitrequest) begin
        pop  = 1'b1;
        load = 1'b1;
      end
    end

    if (complete) begin
      write_d = 1'b0;
      if (pix_count_q != CNT_W'(TOTAL)) begin
        pix_count_d = pix_count_q + CNT_W'(1);
      end
    end

    if (load) begin
      write_d = 1'b1;
      data_d  = mem_q[rd_ptr_q];
      addr_d  = base_q + ADDR_W'(idx_q) * ADDR_W'(BYTES_PER_PIX);
      if (idx_q == IDX_W'(TOTAL - 1)) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!push && pop) occ_d = occ_q - OCC_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          base_d      = frame_base;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          occ_d       = '0;
          idx_d       = '0;
          full_d      = 1'b0;
          calc_flag_d = 1'b0;
          pix_count_d = '0;
          overflow_d  = 1'b0;
        end
      end
      RUN: begin
        if (calc_done) calc_flag_d = 1'b1;
        if (calc_done || calc_flag_q || (pix_count_d == CNT_W'(TOTAL))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_q == '0) && !write_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    pix_ready_d = (state_d == RUN) && (occ_d < OCC_W'(FIFO_DEPTH));
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      idx_q       <= '0;
      full_q      <= 1'b0;
      calc_flag_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      pix_count_q <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      idx_q       <= idx_d;
      full_q      <= full_d;
      calc_flag_q <= calc_flag_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      pix_count_q <= pix_count_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Pixel storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

  assign avm.avm_m0_address   = addr_q;
  assign avm.avm_m0_write     = write_q;
  assign avm.avm_m0_writedata = data_q;
  assign pix_ready            = pix_ready_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign overflow             = overflow_q;
  assign pix_count            = pix_count_q;

endmodule

// File: tb/tb_mand_avm_frame_writer.sv
// Randomized bench for the frame writer with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_mand_avm_frame_writer;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MAX_H      = 4;
  localparam int unsigned MAX_V      = 3;
  localparam int unsigned BPP        = 4;
  localparam int unsigned TOTAL      = MAX_H * MAX_V;
  localparam int unsigned CNT_W      = $clog2(TOTAL + 1);

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              start      = 1'b0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic              pix_valid  = 1'b0;
  logic [DATA_W-1:0] pix_data   = '0;
  logic              calc_done  = 1'b0;
  logic              pix_ready, busy, done, overflow;
  logic [CNT_W-1:0]  pix_count;

  mand_avm_frame_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) avm_if ();

  mand_avm_frame_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_H(MAX_H), .MAX_V(MAX_V), .BYTES_PER_PIX(BPP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .calc_done(calc_done), .avm(avm_if), .busy(busy), .done(done),
    .overflow(overflow), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  // Reference model state: expected writes in order, frame bookkeeping
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];
  int                comp_cyc [$];
  logic [ADDR_W-1:0] cur_base;
  int accepted, completed, first_wr_cyc;
  bit in_run, frame_active, exp_ovf, wr_stuck, start_hold;
  int wr_prob, wr_force;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: slave response, bus/producer scoreboard, then post-edge checks
  task automatic step();
    bit run_nxt, act_nxt;
    logic [ADDR_W-1:0] a_dummy;
    logic [DATA_W-1:0] d_dummy;
    run_nxt = in_run;
    act_nxt = frame_active;
    if (wr_stuck) avm_if.avm_m0_waitrequest = 1'b1;
    else if (wr_force > 0 && avm_if.avm_m0_write) begin
      avm_if.avm_m0_waitrequest = 1'b1;
      wr_force--;
    end else avm_if.avm_m0_waitrequest = ($urandom_range(99) < wr_prob);

    if (avm_if.avm_m0_write) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_addr_q.size() == 0) check("spurious_write", 64'd1, 64'd0);
      else begin
        check("wr_addr", 64'(avm_if.avm_m0_address), 64'(exp_addr_q[0]));
        check("wr_data", 64'(avm_if.avm_m0_writedata), 64'(exp_data_q[0]));
        if (!avm_if.avm_m0_waitrequest) begin
          a_dummy = exp_addr_q.pop_front();
          d_dummy = exp_data_q.pop_front();
          completed++;
          comp_cyc.push_back(cyc);
          if (completed == int'(TOTAL)) run_nxt = 1'b0;
        end
      end
    end

    if (!in_run) check("ready_outside_run", 64'(pix_ready), 64'd0);
    if (in_run && pix_valid) begin
      if (pix_ready) begin
        if (accepted < int'(TOTAL)) begin
          exp_addr_q.push_back(cur_base + ADDR_W'(accepted * int'(BPP)));
          exp_data_q.push_back(pix_data);
        end
        accepted++;
      end else exp_ovf = 1'b1;
    end
    if (in_run && calc_done) run_nxt = 1'b0;
    if (start && !frame_active) begin
      act_nxt = 1'b1;
      run_nxt = 1'b1;
      exp_ovf = 1'b0;
    end

    @(posedge clk);
    #1;
    cyc++;
    in_run       = run_nxt;
    frame_active = act_nxt;
    if (done) begin
      check("done_when_active", 64'(frame_active), 64'd1);
      check("done_after_run", 64'(in_run), 64'd0);
      check("done_queue_empty", 64'(exp_addr_q.size()), 64'd0);
      frame_active = 1'b0;
      done_cnt++;
    end
    check("busy", 64'(busy), 64'(frame_active));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("pix_count", 64'(pix_count), 64'(completed));
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base);
    exp_addr_q.delete();
    exp_data_q.delete();
    comp_cyc.delete();
    accepted     = 0;
    completed    = 0;
    first_wr_cyc = -1;
    cur_base     = base;
    start        = 1'b1;
    frame_base   = base;
    step();
    start        = start_hold;
    check("start_ovf_clear", 64'(overflow), 64'd0);
    check("start_cnt_clear", 64'(pix_count), 64'd0);
  endtask

  task automatic offer(input logic [DATA_W-1:0] d, input bit cd);
    pix_valid = 1'b1;
    pix_data  = d;
    calc_done = cd;
    step();
    pix_valid = 1'b0;
    calc_done = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base_cnt;
    int n;
    base_cnt  = done_cnt;
    n         = 0;
    pix_valid = 1'b0;
    calc_done = 1'b0;
    while (done_cnt == base_cnt && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 64'(done_cnt - base_cnt), 64'd1);
  endtask

  task automatic finish_frame();
    int exp_cnt;
    pix_valid = 1'b0;
    start     = 1'b0;
    if (in_run) begin
      calc_done = 1'b1;
      step();
      calc_done = 1'b0;
    end
    wait_done(200);
    exp_cnt = (accepted < int'(TOTAL)) ? accepted : int'(TOTAL);
    check("frame_count", 64'(pix_count), 64'(exp_cnt));
    check("frame_ovf", 64'(overflow), 64'(exp_ovf));
    step();
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic run_frame(input logic [ADDR_W-1:0] base, input int n_offer,
                           input int vprob, input bit cd_with_last);
    int offered;
    int guard;
    int acc_before;
    bit first;
    offered = 0;
    guard   = 0;
    first   = 1'b1;
    start_frame(base);
    while (offered < n_offer && in_run && guard < 2000) begin
      guard++;
      pix_valid  = ($urandom_range(99) < vprob);
      pix_data   = $urandom;
      frame_base = $urandom;
      if (pix_valid) offered++;
      calc_done  = pix_valid && (offered == n_offer) && cd_with_last;
      acc_before = accepted;
      step();
      if (first && accepted != acc_before) begin
        first = 1'b0;
        check("first_latency", 64'(avm_if.avm_m0_write), 64'd0);
      end
    end
    calc_done = 1'b0;
    finish_frame();
  endtask

  task automatic check_reset_outputs();
    check("rst_write", 64'(avm_if.avm_m0_write), 64'd0);
    check("rst_addr", 64'(avm_if.avm_m0_address), 64'd0);
    check("rst_data", 64'(avm_if.avm_m0_writedata), 64'd0);
    check("rst_count", 64'(pix_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ready", 64'(pix_ready), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    avm_if.avm_m0_waitrequest = 1'b0;
    in_run = 1'b0; frame_active = 1'b0; exp_ovf = 1'b0;
    wr_stuck = 1'b0; start_hold = 1'b0; wr_prob = 0; wr_force = 0;
    accepted = 0; completed = 0; first_wr_cyc = -1; cur_base = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) step();

    // Three consecutive pixels, no stalls: back-to-back writes at base+0/4/8
    wr_prob = 0;
    run_frame(32'h0000_1000, 3, 100, 1'b0);
    check("b2b_writes", 64'(comp_cyc.size()), 64'd3);
    if (comp_cyc.size() == 3) begin
      check("b2b_gap0", 64'(comp_cyc[1] - comp_cyc[0]), 64'd1);
      check("b2b_gap1", 64'(comp_cyc[2] - comp_cyc[1]), 64'd1);
    end

    // First write stalled five cycles; later pixels queue behind it
    wr_force = 5;
    run_frame(32'h0000_2000, 3, 100, 1'b0);
    if (comp_cyc.size() > 0) check("stall_len", 64'(comp_cyc[0] - first_wr_cyc), 64'd5);

    // Slave stuck: one word in the write register plus a full FIFO, rest dropped
    wr_stuck = 1'b1;
    start_frame(32'h0000_3000);
    for (int i = 0; i < 6; i++) offer(DATA_W'(32'hA0 + i), 1'b0);
    check("stuck_accepted", 64'(accepted), 64'(FIFO_DEPTH + 1));
    check("stuck_ready", 64'(pix_ready), 64'd0);
    wr_stuck = 1'b0;
    finish_frame();

    // Start held through the frame with a changing frame_base is ignored
    start_hold = 1'b1;
    run_frame(32'h0000_4000, 4, 100, 1'b1);
    start_hold = 1'b0;

    // Frame fills before calc_done; surplus pixels never reach the bus
    run_frame(32'h0000_6000, int'(TOTAL) + 3, 100, 1'b0);
    run_frame(32'h0000_6000, 2, 100, 1'b0);

    // Address arithmetic wraps modulo the address width
    wr_prob = 30;
    run_frame(32'hFFFF_FFF0, int'(TOTAL), 80, 1'b1);

    // Reset while draining with a write stalled on the bus
    wr_stuck = 1'b1;
    start_frame(32'h0000_7000);
    offer(32'h1111_1111, 1'b0);
    offer(32'h2222_2222, 1'b1);
    step();
    check("drain_pending_write", 64'(avm_if.avm_m0_write), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    frame_active = 1'b0; in_run = 1'b0; exp_ovf = 1'b0;
    accepted = 0; completed = 0; wr_stuck = 1'b0;
    repeat (4) step();

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      wr_prob = $urandom_range(0, 60);
      run_frame($urandom & 32'hFFFF_FFFC, $urandom_range(1, int'(TOTAL) + 3),
                $urandom_range(40, 100), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
